// File: rtl/sram_like_pkg.sv
// Shared types and constants for the SRAM-like responder: size encodings,
// response queue entry layout and the stall LFSR polynomial.
package sram_like_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Taps for x^8+x^6+x^5+x^4+1 on a left-shifting Fibonacci register (bits 7,5,4,3).
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef struct packed {
    logic        is_write;
    logic [31:0] rdata;
    logic [7:0]  stamp;
  } resp_entry_t;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/resp_fifo.sv
// In-order queue of accepted-but-unanswered requests; head is the oldest entry.
// Pointers and occupancy are reset, the entry storage is not.
module resp_fifo
  import sram_like_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        push,
  input  resp_entry_t push_data,
  input  logic        pop,
  output resp_entry_t head,
  output logic        full,
  output logic        empty
);

  localparam int PW = $clog2(DEPTH);

  resp_entry_t     slots [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) slots[wr_ptr] <= push_data;
  end

  assign head  = slots[rd_ptr];
  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/sram_like_responder.sv
// Memory-side responder for the SRAM-like request/response interface: accepts
// in-order requests, answers each with one data_ok after a fixed minimum latency.
module sram_like_responder
  import sram_like_pkg::*;
#(
  parameter int         AW        = 12,
  parameter int         DEPTH     = 4,
  parameter int         LATENCY   = 2,
  parameter int         STALL_EN  = 0,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  logic [31:0]   mem [2**AW];
  logic [AW-1:0] widx;
  logic [7:0]    cnt;
  logic [7:0]    lfsr;
  logic          gate;
  logic          full;
  logic          empty;
  resp_entry_t   push_entry_p0;
  resp_entry_t   head_p0;
  logic [7:0]    age_p0;
  logic          vld_p0;
  logic [31:0]   rdata_p0;
  logic          vld_p1;
  logic [31:0]   rdata_p1;
  logic          unused_bits;

  // size never shapes the transfer: wstrb selects write bytes, reads return the whole word.
  assign unused_bits = ^{size, addr[31:AW+2], addr[1:0]};

  assign widx    = addr[AW+1:2];
  assign gate    = (STALL_EN != 0) ? lfsr[0] : 1'b1;
  assign addr_ok = req & ~full & gate;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt  <= '0;
      lfsr <= LFSR_SEED;
    end else begin
      cnt  <= cnt + 8'd1;
      lfsr <= lfsr_next(lfsr);
    end
  end

  always_ff @(posedge clk) begin
    if (addr_ok && wr) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Stage p0: capture the request into the queue and judge head eligibility.
  assign push_entry_p0 = '{is_write: wr,
                           rdata:    wr ? 32'h0 : mem[widx],
                           stamp:    cnt};

  resp_fifo #(
    .DEPTH (DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (addr_ok),
    .push_data (push_entry_p0),
    .pop       (vld_p0),
    .head      (head_p0),
    .full      (full),
    .empty     (empty)
  );

  // Modular age stays exact since no entry waits anywhere near 256 cycles.
  assign age_p0   = cnt - head_p0.stamp;
  assign vld_p0   = ~empty & (age_p0 >= 8'(LATENCY));
  assign rdata_p0 = (vld_p0 && !head_p0.is_write) ? head_p0.rdata : 32'h0;

  // Stage p1: registered response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      vld_p1   <= vld_p0;
      rdata_p1 <= rdata_p0;
    end
  end

  assign data_ok = vld_p1;
  assign rdata   = rdata_p1;

endmodule
